// File: rtl/apb_router_pkg.sv
// apb_router_pkg: shared constants and helpers for the APB 1-to-N router.
//   TIMEOUT_CYCLES - stalled access cycles before the router answers on the
//                    slave's behalf (APB_ROUTER_TIMEOUT_EN builds only)
//   TIMEOUT_RDATA  - read data returned with a timeout completion
//   DEC_ERR_RDATA  - read data returned when no slave pattern matched
package apb_router_pkg;

    typedef logic [31:0] apb_data_t;

    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam apb_data_t   TIMEOUT_RDATA  = 32'hDEAD_BEEF;
    localparam apb_data_t   DEC_ERR_RDATA  = 32'h0000_0000;

    // Master-side read data: a timeout beats a decode miss, which beats the
    // selected slave's data.
    function automatic apb_data_t resp_rdata(input logic      timed_out,
                                             input logic      dec_miss,
                                             input apb_data_t slv_rdata);
        if (timed_out) begin
            return TIMEOUT_RDATA;
        end
        if (dec_miss) begin
            return DEC_ERR_RDATA;
        end
        return slv_rdata;
    endfunction

endpackage

// File: rtl/apb_router_if.sv
// apb_router_if: master-side APB bus of the router.
//   paddr/pwdata/psel/pwrite/penable - driven by the APB master
//   prdata/pready                    - returned by the router
// modport master: the APB master's view; modport slave: the router's view.
interface apb_router_if
    import apb_router_pkg::*;
#(
    parameter int unsigned a_w = 12
) ();

    logic [a_w-1:0] paddr;
    apb_data_t      pwdata;
    apb_data_t      prdata;
    logic           psel;
    logic           pwrite;
    logic           penable;
    logic           pready;

    modport master (
        output paddr, pwdata, psel, pwrite, penable,
        input  prdata, pready
    );

    modport slave (
        input  paddr, pwdata, psel, pwrite, penable,
        output prdata, pready
    );

endinterface

// File: rtl/apb_router_dec.sv
// apb_router_dec: wildcard address decoder with lowest-index priority.
//   paddr    in  master address
//   paddr_am in  per-slave address patterns; X/Z pattern bits are don't-care
//   sel      out one-hot select of the lowest-indexed matching slave
//   hit_any  out at least one pattern matched
module apb_router_dec
    import apb_router_pkg::*;
#(
    parameter int unsigned slv_c = 4,
    parameter int unsigned a_w   = 12
) (
    input  logic [a_w-1:0]            paddr,
    input  logic [slv_c-1:0][a_w-1:0] paddr_am,
    output logic [slv_c-1:0]          sel,
    output logic                      hit_any
);

    logic [slv_c-1:0] hit;

    // Bitwise form of paddr ==? paddr_am[i]: a pattern bit that is X/Z
    // matches anything, every other bit must equal the address bit.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < slv_c; i++) begin
            hit[i] = 1'b1;
            for (int unsigned b = 0; b < a_w; b++) begin
                if (!$isunknown(paddr_am[i][b]) && (paddr_am[i][b] != paddr[b])) begin
                    hit[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic found;
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < slv_c; i++) begin
            if (hit[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign hit_any = |hit;

endmodule

// File: rtl/apb_router.sv
// apb_router: APB 1-to-N address router.
//   pclk      in  APB clock, all state on the rising edge
//   presetn   in  asynchronous reset, active-high
//   paddr_am  in  per-slave wildcard address patterns (X/Z = don't-care)
//   apb       --  master-side bus (apb_router_if.slave): paddr, pwdata, psel,
//                 pwrite, penable in; prdata, pready out
//   paddr_s, pwdata_s, pwrite_s  out  broadcast copies to every slave
//   psel_s, penable_s            out  select/enable of the decoded slave only
//   prdata_s, pready_s           in   slave responses
// Optional feature macro: APB_ROUTER_TIMEOUT_EN -- completes a transfer with
// TIMEOUT_RDATA after TIMEOUT_CYCLES stalled access cycles.
module apb_router
    import apb_router_pkg::*;
#(
    parameter int unsigned slv_c = 4,
    parameter int unsigned a_w   = 12
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [slv_c-1:0][a_w-1:0] paddr_am,
    apb_router_if.slave               apb,
    output logic [slv_c-1:0][a_w-1:0] paddr_s,
    input  logic [slv_c-1:0][31:0]    prdata_s,
    output logic [slv_c-1:0][31:0]    pwdata_s,
    output logic [slv_c-1:0]          psel_s,
    output logic [slv_c-1:0]          pwrite_s,
    output logic [slv_c-1:0]          penable_s,
    input  logic [slv_c-1:0]          pready_s
);

    logic [slv_c-1:0] sel;
    logic             hit_any;
    logic [slv_c-1:0] sel_q;
    logic             miss_q;
    logic             dec_miss;
    logic             setup_phase;
    apb_data_t        slv_rdata;
    logic             slv_ready;
    logic             timed_out;

    apb_router_dec #(
        .slv_c (slv_c),
        .a_w   (a_w)
    ) u_dec (
        .paddr    (apb.paddr),
        .paddr_am (paddr_am),
        .sel      (sel),
        .hit_any  (hit_any)
    );

    always_comb begin
        paddr_s  = '0;
        pwdata_s = '0;
        pwrite_s = '0;
        for (int unsigned i = 0; i < slv_c; i++) begin
            paddr_s[i]  = apb.paddr;
            pwdata_s[i] = apb.pwdata;
            pwrite_s[i] = apb.pwrite;
        end
    end

    // Select/enable are gated by reset combinationally so an in-flight
    // transfer is dropped the moment reset asserts.
    assign psel_s    = presetn ? '0 : (sel & {slv_c{apb.psel}});
    assign penable_s = presetn ? '0 : (sel & {slv_c{apb.penable}});

    assign setup_phase = apb.psel && !apb.penable;

    // Responding slave is captured at the end of the setup phase and held
    // until the next one, so prdata stays readable after psel drops.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            sel_q  <= '0;
            miss_q <= 1'b1;
        end else if (setup_phase) begin
            sel_q  <= sel;
            miss_q <= !hit_any;
        end
    end

    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b0;
        for (int unsigned i = 0; i < slv_c; i++) begin
            if (sel_q[i]) begin
                slv_rdata = slv_rdata | prdata_s[i];
                slv_ready = slv_ready | pready_s[i];
            end
        end
    end

    assign dec_miss = miss_q || (sel_q == '0);

`ifdef APB_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             access_wait;

    assign access_wait = apb.psel && apb.penable && !dec_miss && !slv_ready;
    assign timed_out   = (to_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            to_cnt <= '0;
        end else if (setup_phase) begin
            to_cnt <= '0;
        end else if (apb.psel && apb.penable && apb.pready) begin
            to_cnt <= '0;
        end else if (access_wait) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign apb.pready = dec_miss || slv_ready || timed_out;
    assign apb.prdata = resp_rdata(timed_out, dec_miss, slv_rdata);

endmodule

// File: tb/tb_apb_router.sv
// tb_apb_router: directed bench for apb_router (slv_c=4, a_w=12).
// Four behavioural slaves hold 256 words each, indexed by paddr[9:2], and
// insert delay[i] wait states per access.
module tb_apb_router;
    import apb_router_pkg::*;

    localparam int unsigned SLV_C = 4;
    localparam int unsigned A_W   = 12;

    logic                      pclk = 1'b0;
    logic                      presetn;
    logic [SLV_C-1:0][A_W-1:0] am;
    logic [SLV_C-1:0][A_W-1:0] paddr_s;
    logic [SLV_C-1:0][31:0]    prdata_s;
    logic [SLV_C-1:0][31:0]    pwdata_s;
    logic [SLV_C-1:0]          psel_s;
    logic [SLV_C-1:0]          pwrite_s;
    logic [SLV_C-1:0]          penable_s;
    logic [SLV_C-1:0]          pready_s;

    apb_router_if #(.a_w(A_W)) bus ();

    apb_router #(
        .slv_c (SLV_C),
        .a_w   (A_W)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .paddr_am  (am),
        .apb       (bus),
        .paddr_s   (paddr_s),
        .prdata_s  (prdata_s),
        .pwdata_s  (pwdata_s),
        .psel_s    (psel_s),
        .pwrite_s  (pwrite_s),
        .penable_s (penable_s),
        .pready_s  (pready_s)
    );

    always #5 pclk = ~pclk;

    logic [31:0] mem   [SLV_C][256];
    int unsigned wcnt  [SLV_C];
    int unsigned delay [SLV_C];

    int vectors     = 0;
    int miscompares = 0;
    logic four_state;

    localparam logic [11:0] ADDR_TBL [4] = '{12'h010, 12'h404, 12'h820, 12'hC3C};
    localparam logic [31:0] DATA_TBL [4] = '{32'h0101_A0A0, 32'h1212_B1B1,
                                             32'h2323_C2C2, 32'h3434_D3D3};

    always_comb begin
        for (int i = 0; i < SLV_C; i++) begin
            prdata_s[i] = mem[i][paddr_s[i][9:2]];
            pready_s[i] = (wcnt[i] >= delay[i]);
        end
    end

    always @(posedge pclk) begin
        if (presetn) begin
            for (int i = 0; i < SLV_C; i++) begin
                wcnt[i] <= 0;
                for (int j = 0; j < 256; j++) mem[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < SLV_C; i++) begin
                if (psel_s[i] && penable_s[i]) begin
                    if (pready_s[i]) begin
                        wcnt[i] <= 0;
                        if (pwrite_s[i]) mem[i][paddr_s[i][9:2]] <= pwdata_s[i];
                    end else begin
                        wcnt[i] <= wcnt[i] + 1;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with psel still high so a
    // following call forms a back-to-back transfer.
    task automatic xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int waits,
                        output logic [3:0] sel_cap, output logic [3:0] en_cap);
        logic done;
        bus.paddr   = addr;
        bus.pwrite  = wr;
        bus.pwdata  = wdata;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int n = 0; n <= 60; n++) begin
            @(negedge pclk);
            if (bus.pready === 1'b1) begin
                done = 1'b1;
                break;
            end
            waits++;
            @(posedge pclk); #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_bound addr=%h: pready=%b, required 1 within 60 cycles", addr, bus.pready);
        end
        rdata   = bus.prdata;
        sel_cap = psel_s;
        en_cap  = penable_s;
        @(posedge pclk); #1;
        bus.penable = 1'b0;
    endtask

    task automatic idle();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        presetn     = 1'b1;
        bus.paddr   = 12'h404;
        bus.pwrite  = 1'b0;
        bus.pwdata  = 32'h0;
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        vectors++;
        if (psel_s !== 4'b0000) begin miscompares++; $display("FAIL rst_psel_s got=%b exp=0000", psel_s); end
        vectors++;
        if (penable_s !== 4'b0000) begin miscompares++; $display("FAIL rst_penable_s got=%b exp=0000", penable_s); end
        vectors++;
        if (bus.pready !== 1'b1) begin miscompares++; $display("FAIL rst_pready got=%b exp=1", bus.pready); end
        vectors++;
        if (bus.prdata !== 32'h0) begin miscompares++; $display("FAIL rst_prdata got=%h exp=00000000", bus.prdata); end
        // Release with a stalled slave 1: routing is live at once, but the
        // response still comes from the reset latch (no slave, ready).
        delay[1] = 5;
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(negedge pclk);
        vectors++;
        if (psel_s !== 4'b0010) begin miscompares++; $display("FAIL post_rst_psel_s got=%b exp=0010", psel_s); end
        vectors++;
        if (penable_s !== 4'b0010) begin miscompares++; $display("FAIL post_rst_penable_s got=%b exp=0010", penable_s); end
        vectors++;
        if (bus.pready !== 1'b1) begin miscompares++; $display("FAIL post_rst_pready got=%b exp=1", bus.pready); end
        @(posedge pclk); #1;
        delay[1] = 0;
        idle();
    endtask

    task automatic test_broadcast();
        bus.paddr  = 12'hABC;
        bus.pwdata = 32'hCAFE_F00D;
        bus.pwrite = 1'b1;
        #1;
        vectors++;
        if (paddr_s !== {4{12'hABC}}) begin miscompares++; $display("FAIL bc_paddr got=%h exp=%h", paddr_s, {4{12'hABC}}); end
        vectors++;
        if (pwdata_s !== {4{32'hCAFE_F00D}}) begin miscompares++; $display("FAIL bc_pwdata got=%h exp=%h", pwdata_s, {4{32'hCAFE_F00D}}); end
        vectors++;
        if (pwrite_s !== 4'b1111) begin miscompares++; $display("FAIL bc_pwrite1 got=%b exp=1111", pwrite_s); end
        vectors++;
        if (psel_s !== 4'b0000) begin miscompares++; $display("FAIL bc_psel_idle got=%b exp=0000", psel_s); end
        bus.pwrite = 1'b0;
        #1;
        vectors++;
        if (pwrite_s !== 4'b0000) begin miscompares++; $display("FAIL bc_pwrite0 got=%b exp=0000", pwrite_s); end
        @(posedge pclk); #1;
    endtask

    task automatic test_write();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        xfer(12'h404, 1'b1, 32'h1234_5678, rd, w, sc, ec);
        idle();
        vectors++;
        if (sc !== 4'b0010) begin miscompares++; $display("FAIL wr_psel_s got=%b exp=0010", sc); end
        vectors++;
        if (ec !== 4'b0010) begin miscompares++; $display("FAIL wr_penable_s got=%b exp=0010", ec); end
        vectors++;
        if (w !== 0) begin miscompares++; $display("FAIL wr_waits got=%0d exp=0", w); end
        vectors++;
        if (mem[1][1] !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_store got=%h exp=12345678", mem[1][1]); end
        vectors++;
        if ((mem[0][1] | mem[2][1] | mem[3][1]) !== 32'h0) begin
            miscompares++; $display("FAIL wr_isolation got=%h exp=00000000", mem[0][1] | mem[2][1] | mem[3][1]);
        end
    endtask

    task automatic test_read();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        xfer(12'h404, 1'b0, 32'h0, rd, w, sc, ec);
        vectors++;
        if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_data got=%h exp=12345678", rd); end
        vectors++;
        if (sc !== 4'b0010) begin miscompares++; $display("FAIL rd_psel_s got=%b exp=0010", sc); end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge pclk);
        vectors++;
        if (bus.prdata !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_late_data got=%h exp=12345678", bus.prdata); end
        @(posedge pclk); #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        delay[2] = 3;
        xfer(12'h820, 1'b1, 32'h0BAD_F00D, rd, w, sc, ec);
        idle();
        vectors++;
        if (w !== 3) begin miscompares++; $display("FAIL ws_wr_waits got=%0d exp=3", w); end
        xfer(12'h820, 1'b0, 32'h0, rd, w, sc, ec);
        idle();
        vectors++;
        if (w !== 3) begin miscompares++; $display("FAIL ws_rd_waits got=%0d exp=3", w); end
        vectors++;
        if (rd !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL ws_rd_data got=%h exp=0badf00d", rd); end
        delay[2] = 0;
    endtask

    task automatic test_all_slaves();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        logic [3:0]  exp_sel;
        for (int i = 0; i < 4; i++) begin
            exp_sel = 4'b0001 << i;
            xfer(ADDR_TBL[i], 1'b1, DATA_TBL[i], rd, w, sc, ec);
            idle();
            vectors++;
            if (sc !== exp_sel) begin miscompares++; $display("FAIL all_wr_sel%0d got=%b exp=%b", i, sc, exp_sel); end
        end
        for (int i = 0; i < 4; i++) begin
            xfer(ADDR_TBL[i], 1'b0, 32'h0, rd, w, sc, ec);
            idle();
            vectors++;
            if (rd !== DATA_TBL[i]) begin miscompares++; $display("FAIL all_rd%0d got=%h exp=%h", i, rd, DATA_TBL[i]); end
        end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        am[1] = 12'h010;
        xfer(12'h010, 1'b0, 32'h0, rd, w, sc, ec);
        idle();
        vectors++;
        if (sc !== 4'b0001) begin miscompares++; $display("FAIL prio_sel got=%b exp=0001", sc); end
        vectors++;
        if (rd !== DATA_TBL[0]) begin miscompares++; $display("FAIL prio_data got=%h exp=%h", rd, DATA_TBL[0]); end
        am[1] = 12'h404;
    endtask

    task automatic test_miss();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        am[3] = 12'hC00;
        xfer(12'hC00, 1'b1, 32'hFFFF_FFFF, rd, w, sc, ec);
        idle();
        am[3]    = 12'h000;
        delay[3] = 5;
        xfer(12'hC00, 1'b0, 32'h0, rd, w, sc, ec);
        idle();
        vectors++;
        if (sc !== 4'b0000) begin miscompares++; $display("FAIL miss_psel_s got=%b exp=0000", sc); end
        vectors++;
        if (ec !== 4'b0000) begin miscompares++; $display("FAIL miss_penable_s got=%b exp=0000", ec); end
        vectors++;
        if (w !== 0) begin miscompares++; $display("FAIL miss_waits got=%0d exp=0", w); end
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL miss_data got=%h exp=00000000", rd); end
        am[3]    = 12'hC3C;
        delay[3] = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        delay[3] = 2;
        xfer(12'h010, 1'b1, 32'h7777_0000, rd, w, sc, ec);
        xfer(12'hC3C, 1'b0, 32'h0, rd, w, sc, ec);
        vectors++;
        if (rd !== DATA_TBL[3]) begin miscompares++; $display("FAIL b2b_rd3 got=%h exp=%h", rd, DATA_TBL[3]); end
        vectors++;
        if (w !== 2) begin miscompares++; $display("FAIL b2b_waits3 got=%0d exp=2", w); end
        vectors++;
        if (sc !== 4'b1000) begin miscompares++; $display("FAIL b2b_sel3 got=%b exp=1000", sc); end
        xfer(12'h010, 1'b0, 32'h0, rd, w, sc, ec);
        idle();
        vectors++;
        if (rd !== 32'h7777_0000) begin miscompares++; $display("FAIL b2b_rd0 got=%h exp=77770000", rd); end
        vectors++;
        if (w !== 0) begin miscompares++; $display("FAIL b2b_waits0 got=%0d exp=0", w); end
        delay[3] = 0;
    endtask

    // Only meaningful where the simulator keeps X/Z in the pattern inputs.
    task automatic test_wildcard();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        logic [11:0] addrs [4];
        logic [3:0]  exp_sel;
        addrs = '{12'h0F0, 12'h5A4, 12'h9FC, 12'hE08};
        am[0] = 12'b00xx_xxxx_xxxx;
        am[1] = 12'b01xx_xxxx_xxxx;
        am[2] = 12'b10xx_xxxx_xxxx;
        am[3] = 12'b11zz_zzzz_zzzz;
        for (int i = 0; i < 4; i++) begin
            exp_sel = 4'b0001 << i;
            xfer(addrs[i], 1'b1, 32'h5A00_0000 + i, rd, w, sc, ec);
            idle();
            vectors++;
            if (sc !== exp_sel) begin miscompares++; $display("FAIL wild_sel%0d got=%b exp=%b", i, sc, exp_sel); end
            xfer(addrs[i], 1'b0, 32'h0, rd, w, sc, ec);
            idle();
            vectors++;
            if (rd !== 32'h5A00_0000 + i) begin miscompares++; $display("FAIL wild_rd%0d got=%h exp=%h", i, rd, 32'h5A00_0000 + i); end
        end
        for (int i = 0; i < 4; i++) am[i] = ADDR_TBL[i];
    endtask

`ifdef APB_ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd;
        int          w;
        logic [3:0]  sc, ec;
        delay[2] = 100;
        xfer(12'h820, 1'b0, 32'h0, rd, w, sc, ec);
        idle();
        vectors++;
        if (w !== 16) begin miscompares++; $display("FAIL to_waits got=%0d exp=16", w); end
        vectors++;
        if (rd !== TIMEOUT_RDATA) begin miscompares++; $display("FAIL to_data got=%h exp=%h", rd, TIMEOUT_RDATA); end
        delay[2] = 0;
    endtask
`endif

    task automatic test_reset_mid();
        delay[2]    = 100;
        bus.paddr   = 12'h820;
        bus.pwrite  = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        vectors++;
        if (bus.pready !== 1'b0) begin miscompares++; $display("FAIL mid_stall_pready got=%b exp=0", bus.pready); end
        vectors++;
        if (psel_s !== 4'b0100) begin miscompares++; $display("FAIL mid_psel_s got=%b exp=0100", psel_s); end
        #2;
        presetn = 1'b1;
        #1;
        vectors++;
        if (psel_s !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_psel_s got=%b exp=0000", psel_s); end
        vectors++;
        if (penable_s !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_penable_s got=%b exp=0000", penable_s); end
        vectors++;
        if (bus.pready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_pready got=%b exp=1", bus.pready); end
        vectors++;
        if (bus.prdata !== 32'h0) begin miscompares++; $display("FAIL mid_rst_prdata got=%h exp=00000000", bus.prdata); end
        @(posedge pclk); #1;
        idle();
        presetn  = 1'b0;
        delay[2] = 0;
        idle();
    endtask

    initial begin
        logic [1:0] probe;
        for (int i = 0; i < SLV_C; i++) begin
            delay[i] = 0;
            am[i]    = ADDR_TBL[i];
        end
        probe      = 2'bx1;
        four_state = $isunknown(probe);

        test_reset();
        test_broadcast();
        test_write();
        test_read();
        test_wait_states();
        test_all_slaves();
        test_priority();
        test_miss();
        test_back_to_back();
        if (four_state) test_wildcard();
`ifdef APB_ROUTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_router.md
# apb_router

APB 1-to-N address router between a single APB master (bridge or CPU-side APB port) and `slv_c` APB slaves. It decodes each master transfer against per-slave wildcard address patterns, forwards select/enable to the matching slave only, and returns that slave's read data and ready to the master. Address, write data and direction are broadcast unmodified to all slaves.

## Interface
- `slv_c`, 4, number of slave ports
- `a_w`, 12, address width
- `pclk`  in  1  APB clock, all state on rising edge
- `presetn`  in  1  reset presetn, asynchronous, active-high; clock pclk
- `paddr_am`  in  `slv_c`×`a_w` (packed)  per-slave address pattern; X/Z bits are don't-care
- `paddr`  in  `a_w`  master address
- `prdata`  out  32  master read data
- `pwdata`  in  32  master write data
- `psel`  in  1  master select
- `pwrite`  in  1  master write (1) / read (0)
- `penable`  in  1  master enable (access phase)
- `pready`  out  1  master ready
- `paddr_s`  out  `slv_c`×`a_w`  slave address (broadcast copy of `paddr`)
- `prdata_s`  in  `slv_c`×32  slave read data
- `pwdata_s`  out  `slv_c`×32  slave write data (broadcast)
- `psel_s`  out  `slv_c`×1  slave select
- `pwrite_s`  out  `slv_c`×1  slave write (broadcast)
- `penable_s`  out  `slv_c`×1  slave enable
- `pready_s`  in  `slv_c`×1  slave ready

## Operation
- Decode: `hit[i] = (paddr ==? paddr_am[i])`; on multiple hits, lowest index wins (one-hot `sel`).
- `psel_s[i] = psel & sel[i]`, `penable_s[i] = penable & sel[i]`; all other slaves see 0.
- `paddr_s[i] = paddr`, `pwdata_s[i] = pwdata`, `pwrite_s[i] = pwrite` for every `i`, regardless of select. Slaves perform their own local offset masking.
- Response slave latch: on a rising edge with `psel & !penable` (setup phase), register `sel_q <= sel` and `miss_q <= ~|hit`. Hold otherwise.
- `prdata = prdata_s[sel_q]`, `pready = pready_s[sel_q]` when `sel_q` is non-zero. Both remain valid after `psel` drops until the next setup phase, so the master may sample `prdata` one cycle late.
- Decode miss (`miss_q`, or `sel_q == 0`): `prdata = 0`, `pready = 1`. No slave is selected and the transfer completes immediately without side effects.

## Timing
- Select, enable, address and data paths are purely combinational, with zero-cycle latency to the slaves.
- Response path muxes from the registered `sel_q`. The latch is updated at the end of the setup phase, so it is valid for the whole access phase.
- An access phase extends while the selected `pready_s` = 0. `pready` mirrors it combinationally.
- Back-to-back transfers: each new setup phase overwrites `sel_q`/`miss_q`.
- Reset (`presetn`=1), asynchronous:
  - `sel_q` = 0, `miss_q` = 1, so `prdata` = 0 and `pready` = 1.
  - `psel_s` and `penable_s` are forced to 0 for as long as reset is asserted.
- Reset asserted mid-transfer aborts routing immediately. The master sees `pready` = 1 and `prdata` = 0.

## Configuration
- `APB_ROUTER_TIMEOUT_EN` defined:
  - A counter runs while `psel & penable & !pready_s[sel_q]`.
  - Once it reaches `TIMEOUT_CYCLES`, the router drives `pready` = 1 and `prdata` = `TIMEOUT_RDATA` for one cycle, completing the master transfer.
  - The counter clears on any setup phase, on transfer completion and on reset.
- Not defined: no counter. The router waits on the slave's `pready_s` indefinitely.

## Structure
- Package `apb_router_pkg`:
  - `TIMEOUT_CYCLES` = 16
  - `TIMEOUT_RDATA` = 32'hDEAD_BEEF
  - `DEC_ERR_RDATA` = 32'h0000_0000
- Sub-module `apb_router_dec`: wildcard compare plus lowest-index priority encoding of `paddr` against `paddr_am`, giving the one-hot `sel` and `hit_any`.

## Test plan
Common setup: `slv_c`=4, `a_w`=12, patterns 00xx…, 01xx…, 10xx…, 11xx…, with slave models indexed by `paddr & 12'h3FF`.

- Write 0x12345678 to 0x404 using the setup-then-access sequence -> only `psel_s[1]`/`penable_s[1]` high. Slave 1 stores the value at offset 0x004.
- Read 0x404 after that write -> `prdata` = 0x12345678, still valid the cycle after `psel` falls.
- 20 random word-aligned writes over 0x000–0xFFF, followed by reads of the same addresses -> every read equals its write. Each address reaches slave `addr[11:10]`.
- Pattern 0x3xx on slave 0 and `paddr_am[1]` overlapping 0x000–0x3FF; read 0x010 -> slave 0 only is selected (lowest index wins).
- Set `paddr_am[3]` = 12'h000 and read 0xC00 -> no slave selected, `pready` = 1, `prdata` = 0.
- Assert `presetn` during an access phase -> `psel_s`/`penable_s` go 0 asynchronously, `pready` = 1. With `APB_ROUTER_TIMEOUT_EN`, hold `pready_s[2]` = 0 -> `pready` = 1 with 0xDEADBEEF after 16 access cycles.
